// File: rtl/regfile_sb.sv
// regfile_sb -- general-purpose register file with an integrated
// pending-write scoreboard.
//
// Decode marks a destination register pending at issue (iss_en/iss_addr);
// writeback (we/wa/wd) stores the result and clears the pending mark.
// Hazard logic reads per-port busy flags and the number of pending entries.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   BYPASS   1 = same-cycle write data forwarded to the read ports
//   ZERO_REG 1 = register 0 reads as zero and ignores writes and issues
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ra1/ra2 -> rd1/rd2   combinational read ports
//   busy1/busy2          entry at ra1/ra2 has a pending write
//   we, wa, wd           synchronous write port (writeback)
//   iss_en, iss_addr     issue strobe, marks iss_addr pending
//   pend_cnt             number of entries currently pending (0..DEPTH)

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;

    logic wr_ok;
    logic iss_ok;
    logic cnt_inc;
    logic cnt_dec;

    // Writes and issues aimed at the hard-wired zero register are dropped.
    assign wr_ok  = we     && !(ZERO_REG && (wa == '0));
    assign iss_ok = iss_en && !(ZERO_REG && (iss_addr == '0));

    // The counter moves only on real bit transitions: re-issuing a pending
    // entry, writing a non-pending entry, or issue+write to the same entry
    // (issue wins, the bit stays set) leave it unchanged.
    assign cnt_inc = iss_ok && !pend[iss_addr];
    assign cnt_dec = wr_ok && pend[wa] && !(iss_ok && (iss_addr == wa));

    // NOTE: every variable written in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok)
            pend_nxt[wa] = 1'b0;
        // Applied after the clear so a same-cycle issue to wa keeps it pending.
        if (iss_ok)
            pend_nxt[iss_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = cnt;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array itself is reset (it is flops, not a RAM macro),
            // because the cycle after reset must read all-zero.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok)
                mem[wa] <= wd;
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign pend_cnt = cnt;

    // Both read ports share one piece of logic, indexed by port number.
    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] rd;
    logic [1:0]             busy;

    assign ra = {ra2, ra1};

    always_comb begin
        rd   = '0;
        busy = '0;
        for (int p = 0; p < 2; p++) begin
            rd[p]   = mem[ra[p]];
            busy[p] = pend[ra[p]];
            // An in-flight write satisfies the read this cycle; a same-cycle
            // issue to the same entry shows up as busy only from next cycle.
            if (BYPASS && wr_ok && (wa == ra[p])) begin
                rd[p]   = wd;
                busy[p] = 1'b0;
            end
            if (ZERO_REG && (ra[p] == '0)) begin
                rd[p]   = '0;
                busy[p] = 1'b0;
            end
        end
    end

    assign rd1   = rd[0];
    assign rd2   = rd[1];
    assign busy1 = busy[0];
    assign busy2 = busy[1];

endmodule
